// File: rtl/rc4_session_arbiter.sv
// Shares one RC4 keystream core between two requesters: round-robin grant, key-length check,
// core clear pulse, watchdog-guarded run and a four-phase req/ack result handshake.
module rc4_session_arbiter #(
  parameter int NUMS_OF_BYTES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_0,
  input  logic                       req_1,
  input  logic [NUMS_OF_BYTES*8-1:0] key_0,
  input  logic [NUMS_OF_BYTES*8-1:0] key_1,
  input  logic [7:0]                 key_length_0,
  input  logic [7:0]                 key_length_1,
  output logic                       ack_0,
  output logic                       ack_1,
  output logic [NUMS_OF_BYTES*8-1:0] ckey_out,
  output logic                       err,
  output logic                       busy,
  output logic                       core_rst_n,
  output logic                       core_start,
  output logic [NUMS_OF_BYTES*8-1:0] core_key,
  output logic [7:0]                 core_key_length,
  input  logic                       core_done,
  input  logic [NUMS_OF_BYTES*8-1:0] core_ckey
);

  localparam int KW = NUMS_OF_BYTES * 8;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    MAX_LEN  = 8'(NUMS_OF_BYTES);
  localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DELIVER = 3'd4;

  logic [2:0]    state;
  logic          grant;
  logic          last_grant;
  logic [CW-1:0] wd_cnt;

  logic          pick;
  logic [KW-1:0] sel_key;
  logic [7:0]    sel_len;
  logic          len_ok;
  logic          req_granted;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick        = (req_0 && req_1) ? ~last_grant : req_1;
    sel_key     = pick ? key_1 : key_0;
    sel_len     = pick ? key_length_1 : key_length_0;
    len_ok      = (sel_len != 8'd0) && (sel_len <= MAX_LEN);
    req_granted = grant ? req_1 : req_0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      grant           <= 1'b0;
      last_grant      <= 1'b1;
      wd_cnt          <= '0;
      ack_0           <= 1'b0;
      ack_1           <= 1'b0;
      err             <= 1'b0;
      busy            <= 1'b0;
      core_start      <= 1'b0;
      core_rst_n      <= 1'b0;
      ckey_out        <= '0;
      core_key        <= '0;
      core_key_length <= '0;
    end else begin
      core_rst_n <= 1'b1;
      case (state)
        S_IDLE: begin
          if (req_0 || req_1) begin
            grant           <= pick;
            last_grant      <= pick;
            core_key        <= sel_key;
            core_key_length <= sel_len;
            busy            <= 1'b1;
            if (len_ok) begin
              state      <= S_CLEAR;
              core_rst_n <= 1'b0;
            end else begin
              state    <= S_DELIVER;
              err      <= 1'b1;
              ckey_out <= '0;
              ack_0    <= ~pick;
              ack_1    <= pick;
            end
          end
        end
        S_CLEAR: begin
          state      <= S_RUN;
          core_start <= 1'b1;
          wd_cnt     <= '0;
        end
        S_RUN: begin
          if (core_done) begin
            state      <= S_CAPTURE;
            core_start <= 1'b0;
          end else if (wd_cnt == WD_LIMIT) begin
            state      <= S_DELIVER;
            core_start <= 1'b0;
            err        <= 1'b1;
            ckey_out   <= '0;
            ack_0      <= ~grant;
            ack_1      <= grant;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        // The core's keystream RAM read settles one cycle after done.
        S_CAPTURE: begin
          state    <= S_DELIVER;
          ckey_out <= core_ckey;
          err      <= 1'b0;
          ack_0    <= ~grant;
          ack_1    <= grant;
        end
        S_DELIVER: begin
          if (!req_granted) begin
            state <= S_IDLE;
            ack_0 <= 1'b0;
            ack_1 <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_session_arbiter.sv
// Scoreboard bench for rc4_session_arbiter with a behavioural RC4 core stub
// (programmable completion latency, or never completing).
module tb_rc4_session_arbiter;

  localparam int NB = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_0, req_1;
  logic [31:0]   key_0, key_1;
  logic [7:0]    key_length_0, key_length_1;
  logic          ack_0, ack_1, err, busy;
  logic [31:0]   ckey_out;
  logic          core_rst_n, core_start;
  logic [31:0]   core_key;
  logic [7:0]    core_key_length;
  logic          core_done;
  logic [31:0]   core_ckey;

  always #5 clk = ~clk;

  rc4_session_arbiter #(.NUMS_OF_BYTES(NB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .req_1(req_1),
    .key_0(key_0), .key_1(key_1),
    .key_length_0(key_length_0), .key_length_1(key_length_1),
    .ack_0(ack_0), .ack_1(ack_1),
    .ckey_out(ckey_out), .err(err), .busy(busy),
    .core_rst_n(core_rst_n), .core_start(core_start),
    .core_key(core_key), .core_key_length(core_key_length),
    .core_done(core_done), .core_ckey(core_ckey)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference RC4: KSA over key bytes, then the first NB keystream bytes, byte n at [n*8+:8].
  function automatic logic [31:0] rc4_ks(input logic [31:0] k, input logic [7:0] len);
    int s[256];
    int i, j, t;
    logic [31:0] r;
    r = '0;
    if (len == 8'd0) return r;
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + int'(k[(n % int'(len)) * 8 +: 8])) & 255;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int n = 0; n < NB; n++) begin
      i = (i + 1) & 255;
      j = (j + s[i]) & 255;
      t = s[i]; s[i] = s[j]; s[j] = t;
      r[n*8 +: 8] = 8'(s[(s[i] + s[j]) & 255]);
    end
    return r;
  endfunction

  // Core stub: done after core_lat cycles of start, keystream valid one cycle after done.
  int core_lat = 3;
  bit hang = 1'b0;
  int core_cnt;
  always @(posedge clk) begin
    if (!core_rst_n) begin
      core_done <= 1'b0;
      core_cnt  <= 0;
      core_ckey <= '0;
    end else if (core_start && !core_done) begin
      core_cnt <= core_cnt + 1;
      if (!hang && core_cnt + 1 >= core_lat) core_done <= 1'b1;
    end else if (core_done) begin
      core_ckey <= rc4_ks(core_key, core_key_length);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] ckey;
  } exp_t;
  exp_t sb[$];

  logic prev_a0 = 0, prev_a1 = 0, prev_start = 0, prev_crst = 0;
  int   clr_cnt = 0, start_rises = 0, start_cyc = 0, ack_cyc = 0;
  logic pre_start_crst = 1'b1;

  always @(negedge clk) begin
    if (rst_n && !core_rst_n) clr_cnt++;
    if (core_start && !prev_start) begin
      start_rises++;
      start_cyc      = cyc;
      pre_start_crst = prev_crst;
    end
    if ((ack_0 && !prev_a0) || (ack_1 && !prev_a1)) begin
      ack_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_port", {31'd0, ack_1}, {31'd0, e.port});
        chk("sb_err", {31'd0, err}, {31'd0, e.err});
        chk("sb_ckey", ckey_out, e.ckey);
      end
    end
    prev_a0    = ack_0;
    prev_a1    = ack_1;
    prev_start = core_start;
    prev_crst  = core_rst_n;
  end

  task automatic push(input logic p, input logic [31:0] k, input logic [7:0] len, input bit timeout);
    exp_t e;
    e.port = p;
    e.err  = timeout || len == 8'd0 || len > 8'(NB);
    e.ckey = e.err ? 32'd0 : rc4_ks(k, len);
    sb.push_back(e);
  endtask

  // One four-phase transaction; lat = negedges from req raise until ack is seen.
  task automatic do_req(input logic p, input logic [31:0] k, input logic [7:0] len,
                        input int hold, output int lat);
    logic got;
    logic [31:0] snap;
    @(negedge clk);
    if (p) begin key_1 = k; key_length_1 = len; req_1 = 1'b1; end
    else   begin key_0 = k; key_length_0 = len; req_0 = 1'b1; end
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      lat++;
      if (p ? ack_1 : ack_0) begin got = 1'b1; break; end
    end
    if (!got) chk("ack_wait_expired", 32'd0, 32'd1);
    snap = ckey_out;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_ack", {31'd0, p ? ack_1 : ack_0}, 32'd1);
      chk("hold_ckey", ckey_out, snap);
    end
    if (p) req_1 = 1'b0; else req_0 = 1'b0;
    @(negedge clk);
    chk("ack_fall", {31'd0, p ? ack_1 : ack_0}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int lat, c0, s0, c1;
    logic seen;
    rst_n = 1'b0; req_0 = 1'b0; req_1 = 1'b0;
    key_0 = '0; key_1 = '0; key_length_0 = '0; key_length_1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {30'd0, ack_1, ack_0}, 32'd0);
    chk("rst_busy_err_start", {29'd0, busy, err, core_start}, 32'd0);
    chk("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("rst_ckey", ckey_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("core_rst_release", {31'd0, core_rst_n}, 32'd1);

    // "Key" on port 0 with the real keystream
    core_lat = 3;
    c0 = clr_cnt; s0 = start_rises;
    push(1'b0, 32'h0079654B, 8'd3, 1'b0);
    do_req(1'b0, 32'h0079654B, 8'd3, 0, lat);
    chk("key_ks_779feb", {8'd0, ckey_out[23:0]}, 32'h00779FEB);
    chk("key_err", {31'd0, err}, 32'd0);
    chk("clear_cycles", clr_cnt - c0, 32'd1);
    chk("start_rises", start_rises - s0, 32'd1);
    chk("clear_before_start", {31'd0, pre_start_crst}, 32'd0);
    chk("run_to_ack", ack_cyc - start_cyc, 32'(core_lat + 2));

    // bad lengths on port 1: core never touched, ack two cycles counting the sampling cycle
    for (int b = 0; b < 2; b++) begin
      logic [7:0] bl;
      bl = (b == 0) ? 8'd0 : 8'd5;
      c0 = clr_cnt; s0 = start_rises;
      push(1'b1, 32'hA5A5A5A5, bl, 1'b0);
      do_req(1'b1, 32'hA5A5A5A5, bl, 0, lat);
      chk("bad_len_lat", lat + 1, 32'd2);
      chk("bad_len_clear", clr_cnt - c0, 32'd0);
      chk("bad_len_start", start_rises - s0, 32'd0);
    end

    // handshake: req_0 held 10 cycles past ack
    core_lat = 5;
    push(1'b0, 32'hDEADBEEF, 8'd4, 1'b0);
    do_req(1'b0, 32'hDEADBEEF, 8'd4, 10, lat);

    // timeout on port 1 with a core that never finishes
    hang = 1'b1;
    push(1'b1, 32'h01020304, 8'd4, 1'b1);
    do_req(1'b1, 32'h01020304, 8'd4, 0, lat);
    chk("timeout_lat", ack_cyc - start_cyc, 32'(TO + 1));
    chk("timeout_start_low", {31'd0, core_start}, 32'd0);
    hang = 1'b0;

    // tie after a port-1 job: expected order 0,1,0
    core_lat = 2;
    push(1'b0, 32'h11223344, 8'd4, 1'b0);
    push(1'b1, 32'h00C0FFEE, 8'd3, 1'b0);
    push(1'b0, 32'h000000AB, 8'd1, 1'b0);
    fork
      begin
        int l0;
        do_req(1'b0, 32'h11223344, 8'd4, 0, l0);
        do_req(1'b0, 32'h000000AB, 8'd1, 0, l0);
      end
      begin
        int l1;
        do_req(1'b1, 32'h00C0FFEE, 8'd3, 0, l1);
      end
    join
    chk("tie_sb_drained", sb.size(), 32'd0);

    // reset in RUN aborts the job with no ack
    core_lat = 8;
    @(negedge clk);
    key_0 = 32'h55667788; key_length_0 = 8'd4; req_0 = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (core_start) begin seen = 1'b1; break; end
    end
    chk("reach_run", {31'd0, seen}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ack", {30'd0, ack_1, ack_0}, 32'd0);
    chk("mid_rst_busy_err_start", {29'd0, busy, err, core_start}, 32'd0);
    chk("mid_rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("mid_rst_ckey", ckey_out, 32'd0);
    chk("mid_rst_core_key", core_key, 32'd0);
    chk("mid_rst_core_len", {24'd0, core_key_length}, 32'd0);
    req_0 = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    c1 = total;
    push(1'b0, 32'h0079654B, 8'd3, 1'b0);
    do_req(1'b0, 32'h0079654B, 8'd3, 0, lat);
    chk("post_rst_ks", {8'd0, ckey_out[23:0]}, 32'h00779FEB);
    chk("final_sb_drained", sb.size(), 32'd0);
    chk("post_rst_checked", 32'(total > c1), 32'd1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
